// File: rtl/i2c_ctrl_sm_if.sv
// Bundle between the I2C control sequencer (slave modport) and its requester/bench (master modport).
// Carries the request, the sampled bus lines and the CS/NS/tx_bit/SCL outputs.
interface i2c_ctrl_sm_if;
  logic        start;
  logic [6:0]  dev_addr;
  logic [15:0] wr_data;
  logic        i2c_sdat_in;
  logic        i2c_sclk_in;
  logic [3:0]  CS;
  logic [3:0]  NS;
  logic        tx_bit;
  logic        i2c_sclk;
  logic        busy;
  logic        done;
  logic        ack_error;

  modport master (
    output start, dev_addr, wr_data, i2c_sdat_in, i2c_sclk_in,
    input  CS, NS, tx_bit, i2c_sclk, busy, done, ack_error
  );

  modport slave (
    input  start, dev_addr, wr_data, i2c_sdat_in, i2c_sclk_in,
    output CS, NS, tx_bit, i2c_sclk, busy, done, ack_error
  );
endinterface

// File: rtl/i2c_ctrl_sm.sv
// I2C master sequencer: one 3-byte write (addr+W, data1, data2) per request, SCL, bit count, ACK check.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL by holding the line low while SCL is released.
module i2c_ctrl_sm #(
  parameter int unsigned CLK_DIV = 125
) (
  input logic          clk,
  input logic          reset_n,
  i2c_ctrl_sm_if.slave bus
);
  localparam int unsigned     DIV_W   = 12;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_WAIT    = 4'd0,
    S_START   = 4'd1,
    S_ADDRESS = 4'd2,
    S_ACK1    = 4'd3,
    S_DATA1   = 4'd4,
    S_ACK2    = 4'd5,
    S_DATA2   = 4'd6,
    S_ACK3    = 4'd7,
    S_STOP    = 4'd8
  } state_t;

  // Raw 4-bit register so corrupted codes 9..15 are representable and decode back to Wait.
  logic [3:0]       cs;
  state_t           ns;
  logic [DIV_W-1:0] div, div_nx;
  logic [1:0]       phase, phase_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]       shift, shift_nx;
  logic [15:0]      data, data_nx;
  logic             ack_error_q, ack_error_nx;
  logic             sclk_q, tx_bit_q, busy_q, done_q;
  logic             stall, tick, bit_end, is_ack, is_data;

`ifdef I2C_CLK_STRETCH_EN
  assign stall = sclk_q && (phase == 2'd1 || phase == 2'd2) && !bus.i2c_sclk_in;
`else
  logic unused_sclk_in;
  assign unused_sclk_in = bus.i2c_sclk_in;
  assign stall          = 1'b0;
`endif

  assign tick    = !stall && (div == DIV_MAX);
  assign bit_end = tick && (phase == 2'd3);
  assign is_ack  = (cs == S_ACK1) || (cs == S_ACK2) || (cs == S_ACK3);
  assign is_data = (cs == S_ADDRESS) || (cs == S_DATA1) || (cs == S_DATA2);

  function automatic logic scl_level(input state_t s, input logic [1:0] ph);
    case (s)
      S_ADDRESS, S_ACK1, S_DATA1, S_ACK2, S_DATA2, S_ACK3: scl_level = (ph == 2'd1) || (ph == 2'd2);
      S_STOP:  scl_level = (ph != 2'd0);
      default: scl_level = 1'b1;
    endcase
  endfunction

  // Next-state decode; a NACK latched in ack_error diverts the Ack state to Stop.
  always_comb begin
    ns = S_WAIT;
    case (cs)
      S_WAIT:    ns = bus.start ? S_START : S_WAIT;
      S_START:   ns = bit_end ? S_ADDRESS : S_START;
      S_ADDRESS: ns = (bit_end && bit_cnt == 3'd0) ? S_ACK1 : S_ADDRESS;
      S_ACK1:    ns = bit_end ? (ack_error_q ? S_STOP : S_DATA1) : S_ACK1;
      S_DATA1:   ns = (bit_end && bit_cnt == 3'd0) ? S_ACK2 : S_DATA1;
      S_ACK2:    ns = bit_end ? (ack_error_q ? S_STOP : S_DATA2) : S_ACK2;
      S_DATA2:   ns = (bit_end && bit_cnt == 3'd0) ? S_ACK3 : S_DATA2;
      S_ACK3:    ns = bit_end ? S_STOP : S_ACK3;
      S_STOP:    ns = bit_end ? S_WAIT : S_STOP;
      default:   ns = S_WAIT;
    endcase
  end

  // Divider, phase, bit counter and byte shifter.
  always_comb begin
    div_nx       = div;
    phase_nx     = phase;
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift;
    data_nx      = data;
    ack_error_nx = ack_error_q;
    if (cs == S_WAIT || ns == S_WAIT) begin
      div_nx     = '0;
      phase_nx   = 2'd0;
      bit_cnt_nx = 3'd7;
      if (cs == S_WAIT && ns == S_START) begin
        shift_nx     = {bus.dev_addr, 1'b0};
        data_nx      = bus.wr_data;
        ack_error_nx = 1'b0;
      end
    end else begin
      if (tick) begin
        div_nx   = '0;
        phase_nx = phase + 2'd1;
      end else if (!stall) begin
        div_nx = div + DIV_W'(1);
      end
      if (is_ack && tick && phase == 2'd2 && bus.i2c_sdat_in) begin
        ack_error_nx = 1'b1;
      end
      // Decrement wraps 0 -> 7, which is the reload for the next byte.
      if (is_data && bit_end) begin
        bit_cnt_nx = bit_cnt - 3'd1;
      end
      if (cs == S_ACK1 && ns == S_DATA1) begin
        shift_nx = data[15:8];
      end
      if (cs == S_ACK2 && ns == S_DATA2) begin
        shift_nx = data[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs          <= S_WAIT;
      div         <= '0;
      phase       <= 2'd0;
      bit_cnt     <= 3'd7;
      shift       <= '0;
      data        <= '0;
      ack_error_q <= 1'b0;
      sclk_q      <= 1'b1;
      tx_bit_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cs          <= ns;
      div         <= div_nx;
      phase       <= phase_nx;
      bit_cnt     <= bit_cnt_nx;
      shift       <= shift_nx;
      data        <= data_nx;
      ack_error_q <= ack_error_nx;
      sclk_q      <= scl_level(ns, phase_nx);
      tx_bit_q    <= shift_nx[bit_cnt_nx];
      busy_q      <= (ns != S_WAIT);
      done_q      <= (cs == S_STOP) && (ns == S_WAIT);
    end
  end

  assign bus.CS        = cs;
  assign bus.NS        = ns;
  assign bus.tx_bit    = tx_bit_q;
  assign bus.i2c_sclk  = sclk_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ack_error = ack_error_q;
endmodule

// File: tb/tb_i2c_ctrl_sm.sv
// Directed bench for i2c_ctrl_sm at CLK_DIV=4 (16 clocks per bit): vector table of full writes,
// plus hand-written reset-mid-transfer and illegal-state sequences.
module tb_i2c_ctrl_sm;
  localparam int unsigned CLK_DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_DONE = 485;
`else
  localparam int STRETCH_DONE = 465;
`endif

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] data;
    int          nack_at;     // 0 none, 1..3 = which ACK slot reads high
    bit          poke;        // second start mid-Data1
    bit          stretch;     // hold SCL low 20 clocks in Address bit 5 phase 1
    int          exp_done_k;  // clocks from driving start to done
    logic        exp_err;
    int          exp_nbytes;
    logic [23:0] exp_bytes;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  i2c_ctrl_sm_if u_if();
  i2c_ctrl_sm #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset_n(reset_n), .bus(u_if));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         k, done_k, nbits, hold;
    logic       prev_sclk, poked;
    logic [3:0] prev_cs;
    logic [7:0] cur;
    logic [7:0] got[$];
    logic [3:0] seq_q[$];
    logic [3:0] exp_q[$];
    bit         seq_ok;
    string      tag;
    tag = $sformatf("v%0d", idx);
    for (int s = 1; s <= 8; s++) begin
      exp_q.push_back(4'(s));
      if (v.nack_at != 0 && s == 2 * v.nack_at + 1) begin
        exp_q.push_back(4'd8);
        break;
      end
    end
    exp_q.push_back(4'd0);

    @(negedge clk);
    u_if.dev_addr = v.addr;
    u_if.wr_data  = v.data;
    u_if.start    = 1'b1;
    done_k = -1; k = 0; nbits = 0; hold = 0; cur = '0;
    prev_sclk = 1'b1; prev_cs = 4'd0; poked = 1'b0;
    while (done_k < 0 && k < 2000) begin
      @(negedge clk);
      k++;
      u_if.start = 1'b0;
      if (k == 1) begin
        check({tag, " busy_after_accept"}, 32'(u_if.busy), 32'd1);
        check({tag, " ack_error_cleared"}, 32'(u_if.ack_error), 32'd0);
      end
      if (u_if.CS != prev_cs) begin
        seq_q.push_back(u_if.CS);
        prev_cs = u_if.CS;
      end
      if (u_if.i2c_sclk && !prev_sclk && (u_if.CS inside {4'd2, 4'd4, 4'd6})) begin
        cur = {cur[6:0], u_if.tx_bit};
        nbits++;
        if (nbits == 8) begin
          got.push_back(cur);
          nbits = 0;
        end
      end
      prev_sclk = u_if.i2c_sclk;
      u_if.i2c_sdat_in = (v.nack_at == 1 && u_if.CS == 4'd3) ||
                         (v.nack_at == 2 && u_if.CS == 4'd5) ||
                         (v.nack_at == 3 && u_if.CS == 4'd7);
      if (v.stretch && k == 53) hold = 20;
      if (hold > 0) begin
        u_if.i2c_sclk_in = 1'b0;
        hold--;
      end else begin
        u_if.i2c_sclk_in = 1'b1;
      end
      if (v.poke && !poked && u_if.CS == 4'd4) begin
        u_if.start    = 1'b1;
        u_if.dev_addr = 7'h00;
        u_if.wr_data  = 16'hFFFF;
        poked = 1'b1;
      end
      if (u_if.done) done_k = k;
    end
    u_if.i2c_sdat_in = 1'b0;
    u_if.i2c_sclk_in = 1'b1;
    check({tag, " done_latency"}, 32'(done_k), 32'(v.exp_done_k));
    check({tag, " ack_error"}, 32'(u_if.ack_error), 32'(v.exp_err));
    check({tag, " busy_at_done"}, 32'(u_if.busy), 32'd0);
    check({tag, " sclk_at_done"}, 32'(u_if.i2c_sclk), 32'd1);
    seq_ok = (seq_q.size() == exp_q.size());
    if (seq_ok) foreach (exp_q[i]) if (seq_q[i] != exp_q[i]) seq_ok = 1'b0;
    check({tag, " cs_sequence_ok"}, 32'(seq_ok), 32'd1);
    check({tag, " byte_count"}, 32'(got.size()), 32'(v.exp_nbytes));
    for (int i = 0; i < v.exp_nbytes && i < got.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(v.exp_bytes[23-8*i -: 8]));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(u_if.done), 32'd0);
    check({tag, " ack_error_sticky"}, 32'(u_if.ack_error), 32'(v.exp_err));
  endtask

  task automatic wait_cs(input logic [3:0] s, input string name);
    int n;
    n = 0;
    while (u_if.CS != s && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (u_if.CS != s) check({name, " wait_timeout"}, 32'(u_if.CS), 32'(s));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{7'h1A, 16'h1E00, 0, 1'b0, 1'b0, 465, 1'b0, 3, 24'h341E00};
    vecs[1] = '{7'h1A, 16'h1E00, 1, 1'b0, 1'b0, 177, 1'b1, 1, 24'h340000};
    vecs[2] = '{7'h55, 16'hA5C3, 3, 1'b0, 1'b0, 465, 1'b1, 3, 24'hAAA5C3};
    vecs[3] = '{7'h7F, 16'hFFFF, 2, 1'b0, 1'b0, 321, 1'b1, 2, 24'hFEFF00};
    vecs[4] = '{7'h1A, 16'h1E00, 0, 1'b1, 1'b0, 465, 1'b0, 3, 24'h341E00};
    vecs[5] = '{7'h1A, 16'h1E00, 0, 1'b0, 1'b1, STRETCH_DONE, 1'b0, 3, 24'h341E00};

    u_if.start = 1'b0;
    u_if.dev_addr = '0;
    u_if.wr_data = '0;
    u_if.i2c_sdat_in = 1'b0;
    u_if.i2c_sclk_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset CS", 32'(u_if.CS), 32'd0);
    check("reset NS", 32'(u_if.NS), 32'd0);
    check("reset busy", 32'(u_if.busy), 32'd0);
    check("reset done", 32'(u_if.done), 32'd0);
    check("reset ack_error", 32'(u_if.ack_error), 32'd0);
    check("reset sclk", 32'(u_if.i2c_sclk), 32'd1);
    check("reset tx_bit", 32'(u_if.tx_bit), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset asserted in Data2 phase 1.
    @(negedge clk);
    u_if.dev_addr = 7'h1A;
    u_if.wr_data  = 16'h1E00;
    u_if.start    = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_cs(4'd6, "rst");
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst CS", 32'(u_if.CS), 32'd0);
    check("rst sclk", 32'(u_if.i2c_sclk), 32'd1);
    check("rst busy", 32'(u_if.busy), 32'd0);
    check("rst bit_cnt", 32'(dut.bit_cnt), 32'd7);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.done !== 1'b0 || u_if.CS !== 4'd0)
        check("rst quiet", {u_if.CS, 27'd0, u_if.done}, 32'd0);
    end
    check("rst idle CS", 32'(u_if.CS), 32'd0);

    // Illegal state code during Data1 must fall back to Wait.
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_cs(4'd4, "ill");
    force dut.cs = 4'd12;
    #1;
    check("ill CS forced", 32'(u_if.CS), 32'd12);
    check("ill NS", 32'(u_if.NS), 32'd0);
    @(posedge clk);
    #1;
    check("ill busy", 32'(u_if.busy), 32'd0);
    check("ill sclk", 32'(u_if.i2c_sclk), 32'd1);
    check("ill done", 32'(u_if.done), 32'd0);
    @(negedge clk);
    release dut.cs;
    @(posedge clk);
    #1;
    check("ill CS wait", 32'(u_if.CS), 32'd0);
    check("ill busy after", 32'(u_if.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_ctrl_sm.md
Name: i2c_ctrl_sm

Overview:
- Upstream control stage for the I2C output-logic block.
- Owns the I2C master state register, next-state logic, SCL generation, bit counter and ACK sampling.
- Presents CS/NS and the current transmit bit to the output-logic block, which drives SDA and its tri-state enable.
- Performs one 3-byte write per request: address+W, data byte 1, data byte 2 (codec register-write format).

Parameters:
- CLK_DIV, 125, system clocks per quarter SCL period (50 MHz / (4*125) = 100 kHz SCL); legal range 2..4095.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request; accepted only when CS=Wait
- dev_addr  input  7  7-bit slave address; latched on accept
- wr_data  input  16  [15:8] sent as Data1, [7:0] as Data2; latched on accept
- i2c_sdat_in  input  1  sampled SDA line
- i2c_sclk_in  input  1  sampled SCL line (used only with the optional feature)
- CS  output  4  current state
- NS  output  4  next state (combinational)
- tx_bit  output  1  bit for the output-logic block to drive during Address/Data states
- i2c_sclk  output  1  SCL drive
- busy  output  1  high whenever CS != Wait
- done  output  1  one-cycle pulse when a transaction ends
- ack_error  output  1  sticky NACK flag

Behaviour:
- State encodings come from the shared I2C states header: Wait=0, Start=1, Address=2, Ack1=3, Data1=4, Ack2=5, Data2=6, Ack3=7, Stop=8. Codes 9..15 return to Wait on the next clock.
- Reset (asynchronous, mid-transaction included): CS=Wait, divider=0, phase=0, bit_cnt=7, i2c_sclk=1, done=0, ack_error=0, shift registers=0. No Stop is issued.
- Wait state:
  - Divider is held at 0 and i2c_sclk=1.
  - start=1 latches the shift byte {dev_addr,1'b0} and wr_data, clears ack_error, and sets NS=Start. CS=Start on the following clock.
  - start asserted in any other state is ignored.
- Timing:
  - Divider counts 0..CLK_DIV-1; a tick occurs at the terminal count.
  - Phase counter 0..3 advances on each tick.
  - Every non-Wait state lasts exactly 4 phases, i.e. 4*CLK_DIV clocks per bit.
- SCL per state:
  - Start: high in all phases.
  - Address/Data/Ack: low in phases 0 and 3, high in phases 1 and 2.
  - Stop: low in phase 0, high in phases 1..3.
- Bit handling:
  - tx_bit = shift[bit_cnt], stable from phase 0 through phase 3.
  - bit_cnt decrements at the end of phase 3.
  - After the bit-0 phase 3, bit_cnt reloads to 7 and the state advances to the matching Ack state.
- Transitions at the end of phase 3:
  - Start->Address
  - Address(bit0)->Ack1
  - Ack1->Data1
  - Data1(bit0)->Ack2
  - Ack2->Data2
  - Data2(bit0)->Ack3
  - Ack3->Stop
  - Stop->Wait
- ACK sampling:
  - In Ack states, i2c_sdat_in is sampled on the phase-2 tick.
  - A sampled 1 sets ack_error, and NS at the end of phase 3 is Stop (abort).
- done: pulses for 1 clock on the Stop->Wait clock, for both normal and aborted transactions.
- ack_error: stays set until the next accepted start.
- Latency: start accepted at clock N; Stop->Wait at N+1+(1+27+1)*4*CLK_DIV. Each Address/Data byte is 8 bits plus 1 ACK, giving 27 bit-times after Start.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- When defined: in phases 1 and 2 with i2c_sclk=1, the divider holds while i2c_sclk_in=0 (slave stretch). Phase timing resumes once the line reads high. Stretching is unbounded.
- When undefined: i2c_sclk_in is ignored and timing is purely free-running.

Test Plan:
- CLK_DIV=4, start with dev_addr=0x1A, wr_data=0x1E00, SDA ACK low on every ACK -> address byte shifts out 0x34 MSB-first, then 0x1E, then 0x00. done pulses exactly 1+29*16 clocks after accept; ack_error=0.
- Same stimulus with SDA high during Ack1 -> ack_error=1, CS goes Ack1->Stop->Wait, Data1 never entered, done pulses once.
- Second start pulse asserted mid-Data1 -> ignored. CS sequence unchanged, latched wr_data unchanged.
- reset_n low during Data2 phase 1 -> same cycle CS=Wait, i2c_sclk=1, bit_cnt=7, busy=0, no done pulse.
- With I2C_CLK_STRETCH_EN: hold i2c_sclk_in low for 20 clocks in Address bit 5 phase 1 -> transaction completes 20 clocks later than the unstretched run. Without the macro, the completion time is unchanged.
- Force CS to an illegal code (12) via bench force/release -> Wait on the next clock, busy=0, i2c_sclk=1.
